// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: instruction-memory read port, redirect request and
// the valid/ready instruction stream toward decode.
interface inst_fetch_if #(
  parameter int ISIZE = 17,
  parameter int MSIZE = 32
);
  logic [MSIZE-1:0] imem_ip;
  logic [ISIZE-1:0] imem_inst;
  logic             redirect_valid;
  logic [MSIZE-1:0] redirect_pc;
  logic             out_valid;
  logic             out_ready;
  logic [ISIZE-1:0] out_inst;
  logic [MSIZE-1:0] out_pc;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs;
  logic [4:0]       out_rt;
  logic [1:0]       out_op;
  logic             done;

  // Fetch stage side.
  modport master (
    output imem_ip,
    input  imem_inst,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output out_rd,
    output out_rs,
    output out_rt,
    output out_op,
    output done
  );

  // Memory / redirect source / decode side.
  modport slave (
    input  imem_ip,
    output imem_inst,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  out_rd,
    input  out_rs,
    input  out_rt,
    input  out_op,
    input  done
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, one combinational memory read per cycle,
// 2-entry {pc, inst} FIFO toward decode, redirect/flush and stop at LAST_PC.
module inst_fetch #(
  parameter int ISIZE    = 17,
  parameter int MSIZE    = 32,
  parameter int RESET_PC = 4,
  parameter int PC_STEP  = 4,
  parameter int LAST_PC  = 1020
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_fetch_if.master bus
);

  typedef struct packed {
    logic [MSIZE-1:0] pc;
    logic [ISIZE-1:0] inst;
  } entry_t;

  // Entry 0 is always the head (oldest) when count_q != 0.
  entry_t [1:0]     fifo_q, fifo_d;
  logic   [1:0]     count_q, count_d;
  logic [MSIZE-1:0] pc_q, pc_d;
  logic             done_q, done_d;

  logic             valid;
  logic             pop;
  logic             fetch;
  logic   [1:0]     count_after_pop;
  entry_t           new_entry;
  entry_t           head;

  assign valid           = (count_q != 2'd0);
  assign pop             = valid & bus.out_ready;
  assign count_after_pop = count_q - {1'b0, pop};
  assign fetch           = !done_q && !bus.redirect_valid &&
                           (count_q != 2'd2 || pop);
  assign new_entry       = '{pc: pc_q, inst: bus.imem_inst};

  always_comb begin
    // NOTE: every _d gets its current value first so no path through this
    // block leaves a signal unassigned, which would infer a latch.
    fifo_d  = fifo_q;
    count_d = count_q;
    pc_d    = pc_q;
    done_d  = done_q;

    if (bus.redirect_valid) begin
      // Redirect wins: any pop this cycle is void and nothing is pushed.
      count_d = 2'd0;
      pc_d    = {bus.redirect_pc[MSIZE-1:2], 2'b00};
      done_d  = 1'b0;
    end else begin
      if (pop) begin
        fifo_d[0] = fifo_q[1];
      end
      count_d = count_after_pop;
      if (fetch) begin
        if (count_after_pop == 2'd0) begin
          fifo_d[0] = new_entry;
        end else begin
          fifo_d[1] = new_entry;
        end
        count_d = count_after_pop + 2'd1;
        if (pc_q == MSIZE'(LAST_PC)) begin
          done_d = 1'b1;
        end else begin
          pc_d = pc_q + MSIZE'(PC_STEP);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two FIFO slots are reset with the control state; at this
      // depth it is free and keeps stale data from ever reaching out_*.
      fifo_q  <= '0;
      count_q <= 2'd0;
      pc_q    <= MSIZE'(RESET_PC);
      done_q  <= 1'b0;
    end else begin
      fifo_q  <= fifo_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  assign head = valid ? fifo_q[0] : '0;

  assign bus.imem_ip   = pc_q;
  assign bus.out_valid = valid;
  assign bus.out_inst  = head.inst;
  assign bus.out_pc    = head.pc;
  assign bus.out_rd    = head.inst[16:12];
  assign bus.out_rs    = head.inst[11:7];
  assign bus.out_rt    = head.inst[6:2];
  assign bus.out_op    = head.inst[1:0];
  assign bus.done      = done_q;

endmodule
